mux_sel_sequencer: RTL and testbench

- Round-robin select generator that sits directly upstream of the 4:1 mux and drives its 2-bit select `s`.
- Watches four channel-request lines and grants one channel at a time.
- Holds each grant for a programmable dwell time, then rotates to the next requester.
- Gives downstream logic a stable, registered select plus a valid flag and a one-hot grant.

---
 rtl/mux_sel_sequencer.sv | 116 +++++++++++
 tb/tb_mux_sel_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for a 4:1 mux. It grants one requesting channel at a time,
// holds the grant for up to DWELL cycles, and drives a registered select, one-hot grant and valid.
module mux_sel_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       rel,
  output logic [1:0] s,
  output logic [3:0] gnt,
  output logic       sel_valid
);

  localparam logic [CNT_W-1:0] Reload = CNT_W'(DWELL - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       s_q, s_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;

  logic       end_evt;
  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;

  assign end_evt = (cnt_q == '0) || rel || !req[s_q];

  // On an end event the pointer moves to the current channel in the same cycle,
  // so the arbiter searches from there and sees the current requester last.
  assign base = (state_q == StActive && end_evt) ? s_q : ptr_q;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        if (en && found) begin
          state_d = StActive;
          s_d     = win;
          gnt_d   = 4'b0001 << win;
          valid_d = 1'b1;
          cnt_d   = Reload;
        end
      end
      StActive: begin
        if (!end_evt) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ptr_d = s_q;
          if (en && found) begin
            s_d     = win;
            gnt_d   = 4'b0001 << win;
            valid_d = 1'b1;
            cnt_d   = Reload;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= 2'b11;
      s_q     <= 2'b00;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign s         = s_q;
  assign gnt       = gnt_q;
  assign sel_valid = valid_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: rotation, re-grant, early release, withdrawal,
// enable gating and asynchronous reset mid-grant, all with hand-computed expectations.
module tb_mux_sel_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       rel;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       sel_valid;

  int checks;
  int failures;

  mux_sel_sequencer #(
    .DWELL(4),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .rel      (rel),
    .s        (s),
    .gnt      (gnt),
    .sel_valid(sel_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] es, input logic [3:0] eg,
                     input logic ev);
    checks++;
    assert ({s, gnt, sel_valid} === {es, eg, ev})
    else begin
      failures++;
      $error("FAIL %s: got s=%b gnt=%b valid=%b, expected s=%b gnt=%b valid=%b",
             tag, s, gnt, sel_valid, es, eg, ev);
    end
  endtask

  // Assert reset, load the given inputs, then release just after a rising edge.
  task automatic do_reset(input logic [3:0] r, input logic e);
    rst_n = 1'b0;
    req   = r;
    en    = e;
    rel   = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    en       = 1'b0;
    req      = 4'b0000;
    rel      = 1'b0;
    #1;

    // Reset state and full-rotation fairness.
    do_reset(4'b1111, 1'b1);
    chk("reset_state", 2'b00, 4'b0000, 1'b0);
    step();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("rotate_g%0d_c%0d", g, c), 2'(g % 4), 4'b0001 << (g % 4), 1'b1);
        step();
      end
    end

    // Single requester is re-granted back-to-back.
    do_reset(4'b0100, 1'b1);
    step();
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("regrant_c%0d", c), 2'b10, 4'b0100, 1'b1);
      step();
    end

    // Early release hands over to ch3 with a full reloaded dwell.
    do_reset(4'b0010, 1'b1);
    step();
    chk("rel_ch1_c1", 2'b01, 4'b0010, 1'b1);
    step();
    req = 4'b1010;
    rel = 1'b1;
    step();
    rel = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rel_ch3_c%0d", c), 2'b11, 4'b1000, 1'b1);
      step();
    end
    chk("rel_back_ch1", 2'b01, 4'b0010, 1'b1);

    // Withdrawal ends the grant; a fresh request is granted one edge later.
    do_reset(4'b0001, 1'b1);
    step();
    chk("wd_ch0", 2'b00, 4'b0001, 1'b1);
    req = 4'b0000;
    step();
    chk("wd_idle", 2'b00, 4'b0000, 1'b0);
    req = 4'b0001;
    step();
    chk("wd_regrant", 2'b00, 4'b0001, 1'b1);

    // en low lets ch2 finish its dwell, then blocks; re-enable grants ch3.
    do_reset(4'b0100, 1'b1);
    step();
    req = 4'b1111;
    en  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("en_ch2_c%0d", c), 2'b10, 4'b0100, 1'b1);
      step();
    end
    chk("en_idle0", 2'b10, 4'b0000, 1'b0);
    step();
    chk("en_idle1", 2'b10, 4'b0000, 1'b0);
    en = 1'b1;
    step();
    chk("en_ch3", 2'b11, 4'b1000, 1'b1);

    // Asynchronous reset mid-grant clears outputs without a clock edge.
    do_reset(4'b1000, 1'b1);
    step();
    chk("ar_ch3", 2'b11, 4'b1000, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async", 2'b00, 4'b0000, 1'b0);
    req = 4'b1111;
    step();
    rst_n = 1'b1;
    step();
    chk("ar_first_ch0", 2'b00, 4'b0001, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
